usb2_ts_feeder: RTL

- Writer for the EP3 isochronous IN endpoint buffer (transport stream path).
- Takes a byte-serial MPEG-TS stream in the ext_clk domain and aligns it to 188-byte packets.
- Packs whole packets into the endpoint buffer through the buf_in write/commit handshake.
- Commits only complete packets, so the host never receives a torn TS packet.

---
 rtl/usb2_ts_feeder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/usb2_ts_feeder.sv
// usb2_ts_feeder: aligns a byte-serial MPEG-TS stream to PKT_LEN-byte packets and writes
// whole packets into the EP3 isochronous IN buffer, committing only complete packets.
module usb2_ts_feeder #(
  parameter int unsigned PKT_LEN         = 188,
  parameter int unsigned PKTS_PER_COMMIT = 5,
  parameter int unsigned FLUSH_CYCLES    = 65535
) (
  input  logic        ext_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  ts_data,
  input  logic        ts_valid,
  input  logic        ts_start,
  output logic [10:0] buf_in_addr,
  output logic [7:0]  buf_in_data,
  output logic        buf_in_wren,
  input  logic        buf_in_ready,
  output logic        buf_in_commit,
  output logic [10:0] buf_in_commit_len,
  input  logic        buf_in_commit_ack,
  output logic [15:0] drop_count,
  output logic [15:0] sync_err_count
);

  localparam int unsigned BC_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned PC_W = $clog2(PKTS_PER_COMMIT + 1);
  localparam logic [BC_W-1:0] LAST_BYTE   = BC_W'(PKT_LEN - 1);
  localparam logic [PC_W-1:0] FULL_PKTS   = PC_W'(PKTS_PER_COMMIT);
  localparam logic [10:0]     FULL_LEN    = 11'(PKT_LEN * PKTS_PER_COMMIT);
  localparam logic [15:0]     FLUSH_LIMIT = 16'(FLUSH_CYCLES);

  if (PKT_LEN * PKTS_PER_COMMIT > 2048) begin : g_len_check
    $error("usb2_ts_feeder: PKT_LEN*PKTS_PER_COMMIT exceeds the 2048-byte endpoint buffer");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_FILL, ST_COMMIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [10:0]     r_wr_ptr, w_wr_ptr_nxt;
  logic [10:0]     r_pkt_base, w_pkt_base_nxt;
  logic [BC_W-1:0] r_byte_cnt, w_byte_cnt_nxt;
  logic [PC_W-1:0] r_pkt_count, w_pkt_count_nxt;
  logic [15:0]     r_idle_cnt, w_idle_nxt;
  logic [10:0]     w_addr_nxt, w_len_nxt, w_flush_len;
  logic [7:0]      w_data_nxt;
  logic            w_wren_nxt, w_commit_nxt;
  logic [15:0]     w_drop_nxt, w_sync_nxt;
  logic            w_start_ok, w_seq_ok, w_idle_expired;

  assign w_start_ok     = ts_start && (ts_data == 8'h47);
  // Byte 0 of a packet must be a qualified sync byte; every other byte must not carry ts_start.
  assign w_seq_ok       = (r_byte_cnt == '0) ? w_start_ok : !ts_start;
  assign w_idle_expired = (r_idle_cnt == FLUSH_LIMIT);
  assign w_flush_len    = 11'(32'(r_pkt_count) * PKT_LEN);

  always_comb begin
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_pkt_base_nxt  = r_pkt_base;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_pkt_count_nxt = r_pkt_count;
    w_idle_nxt      = r_idle_cnt;
    w_wren_nxt      = 1'b0;
    w_addr_nxt      = buf_in_addr;
    w_data_nxt      = buf_in_data;
    w_commit_nxt    = buf_in_commit;
    w_len_nxt       = buf_in_commit_len;
    w_drop_nxt      = drop_count;
    w_sync_nxt      = sync_err_count;

    case (r_state)
      ST_IDLE: begin
        w_wr_ptr_nxt    = '0;
        w_pkt_base_nxt  = '0;
        w_byte_cnt_nxt  = '0;
        w_pkt_count_nxt = '0;
        w_idle_nxt      = '0;
        if (ts_valid && enable && (drop_count != '1)) w_drop_nxt = drop_count + 16'd1;
        if (enable && buf_in_ready) w_state_nxt = ST_HUNT;
      end

      ST_HUNT: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (ts_valid) begin
          w_idle_nxt = '0;
          if (w_start_ok) begin
            w_wren_nxt     = 1'b1;
            w_addr_nxt     = r_wr_ptr;
            w_data_nxt     = ts_data;
            w_wr_ptr_nxt   = r_wr_ptr + 11'd1;
            w_byte_cnt_nxt = BC_W'(1);
            w_state_nxt    = ST_FILL;
          end
        end else if (!w_idle_expired) begin
          w_idle_nxt = r_idle_cnt + 16'd1;
        end else if (r_pkt_count != '0) begin
          w_wr_ptr_nxt   = r_pkt_base;
          w_byte_cnt_nxt = '0;
          w_commit_nxt   = 1'b1;
          w_len_nxt      = w_flush_len;
          w_state_nxt    = ST_COMMIT;
        end
      end

      ST_FILL: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (ts_valid) begin
          w_idle_nxt = '0;
          if (w_seq_ok) begin
            w_wren_nxt   = 1'b1;
            w_addr_nxt   = r_wr_ptr;
            w_data_nxt   = ts_data;
            w_wr_ptr_nxt = r_wr_ptr + 11'd1;
            if (r_byte_cnt == LAST_BYTE) begin
              w_byte_cnt_nxt  = '0;
              w_pkt_base_nxt  = r_wr_ptr + 11'd1;
              w_pkt_count_nxt = r_pkt_count + PC_W'(1);
              if (r_pkt_count + PC_W'(1) == FULL_PKTS) begin
                w_commit_nxt = 1'b1;
                w_len_nxt    = FULL_LEN;
                w_state_nxt  = ST_COMMIT;
              end
            end else begin
              w_byte_cnt_nxt = r_byte_cnt + BC_W'(1);
            end
          end else begin
            if (sync_err_count != '1) w_sync_nxt = sync_err_count + 16'd1;
            // A misplaced but valid sync byte restarts the current packet in place.
            if (w_start_ok) begin
              w_wren_nxt     = 1'b1;
              w_addr_nxt     = r_pkt_base;
              w_data_nxt     = ts_data;
              w_wr_ptr_nxt   = r_pkt_base + 11'd1;
              w_byte_cnt_nxt = BC_W'(1);
            end else begin
              w_wr_ptr_nxt   = r_pkt_base;
              w_byte_cnt_nxt = '0;
              w_state_nxt    = ST_HUNT;
            end
          end
        end else if (!w_idle_expired) begin
          w_idle_nxt = r_idle_cnt + 16'd1;
        end else if (r_pkt_count != '0) begin
          w_wr_ptr_nxt   = r_pkt_base;
          w_byte_cnt_nxt = '0;
          w_commit_nxt   = 1'b1;
          w_len_nxt      = w_flush_len;
          w_state_nxt    = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        if (ts_valid && enable && (drop_count != '1)) w_drop_nxt = drop_count + 16'd1;
        if (buf_in_commit_ack) begin
          w_commit_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ext_clk) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_wr_ptr          <= '0;
      r_pkt_base        <= '0;
      r_byte_cnt        <= '0;
      r_pkt_count       <= '0;
      r_idle_cnt        <= '0;
      buf_in_addr       <= '0;
      buf_in_data       <= '0;
      buf_in_wren       <= 1'b0;
      buf_in_commit     <= 1'b0;
      buf_in_commit_len <= '0;
      drop_count        <= '0;
      sync_err_count    <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_wr_ptr          <= w_wr_ptr_nxt;
      r_pkt_base        <= w_pkt_base_nxt;
      r_byte_cnt        <= w_byte_cnt_nxt;
      r_pkt_count       <= w_pkt_count_nxt;
      r_idle_cnt        <= w_idle_nxt;
      buf_in_addr       <= w_addr_nxt;
      buf_in_data       <= w_data_nxt;
      buf_in_wren       <= w_wren_nxt;
      buf_in_commit     <= w_commit_nxt;
      buf_in_commit_len <= w_len_nxt;
      drop_count        <= w_drop_nxt;
      sync_err_count    <= w_sync_nxt;
    end
  end

endmodule
